// File: rtl/updown_counter_mux_disp.sv
// Up/down hex counter with load, wrap/saturate, terminal-count pulse and threshold flag,
// plus a time-multiplexed active-low 7-segment driver covering every digit.
module updown_counter_mux_disp #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  dec,
    input  logic                  load,
    input  logic                  sat_mode,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic [4*DIGITS-1:0]   cmp_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  above,
    output logic                  tc,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [W-1:0]  CNT_MAX   = '1;

    logic [PW-1:0] r_presc;
    logic [W-1:0]  r_count;
    logic          r_tc;
    logic [SW-1:0] r_scan_cnt;
    logic [IW-1:0] r_idx;

    logic          w_tick;
    logic          w_at_bound;
    logic [3:0]    w_digits [DIGITS];
    logic [3:0]    w_nibble;

    assign w_tick     = (r_presc == TICK_LAST);
    assign w_at_bound = dec ? (r_count == '0) : (r_count == CNT_MAX);

    // A load restarts the tick period so the next step is a full TICK_DIV later.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (load || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= load_value;
            r_tc    <= 1'b0;
        end else if (enable && w_tick) begin
            r_tc <= w_at_bound;
            if (!(w_at_bound && sat_mode)) begin
                r_count <= dec ? r_count - 1'b1 : r_count + 1'b1;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_digits[gi] = r_count[4*gi +: 4];
            assign an[gi]       = (r_idx != IW'(gi));
        end
    endgenerate

    assign w_nibble = w_digits[r_idx];
    assign count    = r_count;
    assign tc       = r_tc;
    assign above    = (r_count > cmp_value);
    assign dp       = (r_idx == '0) ? ~above : 1'b1;

    always_comb begin
        seg = 7'b1111111;
        case (w_nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_updown_counter_mux_disp.sv
// Bench for updown_counter_mux_disp (DIGITS=2, TICK_DIV=4, SCAN_DIV=3): arithmetic model
// compared every cycle, plus hand-computed checkpoints along a directed sequence.
module tb_updown_counter_mux_disp;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 3;
    localparam int MAXV     = 255;

    logic       clk_in = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       dec = 1'b0;
    logic       load = 1'b0;
    logic       sat_mode = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic [7:0] cmp_value = 8'hFF;
    logic [7:0] count;
    logic       above;
    logic       tc;
    logic [1:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_tests = 0;
    int n_fail  = 0;

    updown_counter_mux_disp #(
        .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk_in(clk_in), .reset_n(reset_n), .enable(enable), .dec(dec), .load(load),
        .sat_mode(sat_mode), .load_value(load_value), .cmp_value(cmp_value),
        .count(count), .above(above), .tc(tc), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk_in = ~clk_in;

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_since = edges since last load/reset, m_cyc = edges since reset.
    int m_count = 0;
    int m_since = 0;
    int m_cyc   = 0;
    int m_tc    = 0;

    always @(posedge clk_in or negedge reset_n) begin
        int nxt;
        int ntc;
        if (!reset_n) begin
            m_count <= 0; m_since <= 0; m_cyc <= 0; m_tc <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (load) begin
                m_count <= int'(load_value); m_since <= 0; m_tc <= 0;
            end else begin
                m_since <= m_since + 1;
                if (enable && (m_since % TICK_DIV == TICK_DIV - 1)) begin
                    nxt = dec ? m_count - 1 : m_count + 1;
                    ntc = 0;
                    if (nxt > MAXV) begin ntc = 1; nxt = sat_mode ? MAXV : 0; end
                    if (nxt < 0)    begin ntc = 1; nxt = sat_mode ? 0 : MAXV; end
                    m_count <= nxt; m_tc <= ntc;
                end else begin
                    m_tc <= 0;
                end
            end
        end
    end

    bit cmp_on = 1'b0;

    always @(negedge clk_in) begin
        int idx;
        int e_above;
        if (cmp_on) begin
            idx     = (m_cyc / SCAN_DIV) % DIGITS;
            e_above = (m_count > int'(cmp_value)) ? 1 : 0;
            check("count", int'(count), m_count);
            check("tc",    int'(tc),    m_tc);
            check("above", int'(above), e_above);
            check("an",    int'(an),    (~(1 << idx)) & 3);
            check("seg",   int'(seg),   int'(seg_tab[(m_count >> (4 * idx)) & 15]));
            check("dp",    int'(dp),    (idx == 0) ? 1 - e_above : 1);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    initial begin
        int seen_lo;
        int seen_hi;
        #2 reset_n = 1'b0;
        #1 check("rst_count", int'(count), 0);
        check("rst_an", int'(an), 2'b10);
        check("rst_seg", int'(seg), 7'b0000001);
        cmp_on = 1'b1;
        edges(2);
        reset_n = 1'b1; enable = 1'b1; dec = 1'b0;

        // 40 edges counting up: one step per 4 edges.
        edges(40);
        check("up40_count", int'(count), 8'h0A);
        $display("[TB] up run: count=0x%0h", count);

        // Wrap from 0xFF in wrap mode.
        load_value = 8'hFE; load = 1'b1; sat_mode = 1'b0;
        edges(1); load = 1'b0;
        check("load_fe", int'(count), 8'hFE);
        edges(4); check("wrap_ff", int'(count), 8'hFF);
        edges(4); check("wrap_00", int'(count), 8'h00); check("wrap_tc", int'(tc), 1);
        edges(1); check("wrap_tc_clr", int'(tc), 0);
        $display("[TB] wrap up: count=0x%0h", count);

        // Saturate at 0xFF.
        sat_mode = 1'b1; load = 1'b1;
        edges(1); load = 1'b0;
        edges(8); check("sat_ff", int'(count), 8'hFF); check("sat_tc", int'(tc), 1);
        edges(4); check("sat_ff2", int'(count), 8'hFF); check("sat_tc2", int'(tc), 1);
        $display("[TB] saturate up: count=0x%0h", count);

        // Down from 0x01: saturate at 0, then wrap to 0xFF.
        load_value = 8'h01; load = 1'b1; dec = 1'b1;
        edges(1); load = 1'b0;
        edges(4); check("dn_00", int'(count), 8'h00); check("dn_tc0", int'(tc), 0);
        edges(4); check("dn_sat00", int'(count), 8'h00); check("dn_sat_tc", int'(tc), 1);
        sat_mode = 1'b0;
        edges(4); check("dn_wrap", int'(count), 8'hFF); check("dn_wrap_tc", int'(tc), 1);
        $display("[TB] down: count=0x%0h", count);

        // Load coinciding with a tick edge wins and restarts the prescaler.
        dec = 1'b0;
        edges(3);
        load_value = 8'h10; load = 1'b1;
        edges(1); load = 1'b0;
        check("ld_tick", int'(count), 8'h10);
        edges(3); check("ld_hold", int'(count), 8'h10);
        edges(1); check("ld_step", int'(count), 8'h11);
        $display("[TB] load on tick: count=0x%0h", count);

        // Display scan of 0x3A.
        enable = 1'b0; load_value = 8'h3A; load = 1'b1; cmp_value = 8'h39;
        edges(1); load = 1'b0;
        #1 check("above_1", int'(above), 1);
        seen_lo = 0; seen_hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (an == 2'b10) begin
                seen_lo++;
                check("scan_A_seg", int'(seg), 7'b0001000);
                check("scan_A_dp", int'(dp), 0);
            end else begin
                seen_hi++;
                check("scan_3_seg", int'(seg), 7'b0000110);
                check("scan_3_dp", int'(dp), 1);
            end
            edges(1);
        end
        check("scan_lo_cnt", seen_lo, 6);
        check("scan_hi_cnt", seen_hi, 6);
        cmp_value = 8'h3A;
        #1 check("above_0", int'(above), 0);
        $display("[TB] scan: done for count=0x%0h", count);

        // Asynchronous reset mid-count and mid-scan.
        enable = 1'b1;
        edges(5);
        #1 reset_n = 1'b0;
        #1 check("arst_count", int'(count), 0);
        check("arst_an", int'(an), 2'b10);
        check("arst_seg", int'(seg), 7'b0000001);
        check("arst_tc", int'(tc), 0);
        edges(2);
        reset_n = 1'b1;
        edges(4); check("post_rst", int'(count), 1);
        $display("[TB] async reset: count=0x%0h", count);

        edges(1);
        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
